seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit 7-segment display driver for the clock datapath.
- Captures a packed BCD word plus decimal points into a shadow register at frame boundaries, so the display never tears mid-frame.
- Scans the digits one-hot with an anti-ghosting blank window and drives registered segment/digit outputs of configurable polarity.
- Sits between the time-keeping counters and the chip output pins.

Parameters:
- NUM_DIGITS, 6, number of digits scanned (2..8).
- SCAN_DIV, 1024, clk cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off.
- SEG_ACTIVE_LOW, 0, 1 = segment/dp outputs active-low (common anode).
- DIG_ACTIVE_LOW, 0, 1 = digit_sel outputs active-low.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  display enable.
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit 0 (least significant) = bcd_in[3:0].
- dp_in  in  NUM_DIGITS  decimal point per digit.
- update_req  in  1  pulse: request a shadow load at the next frame boundary.
- seg_out  out  7  segments a..g; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dp_out  out  1  decimal point of the current digit.
- digit_sel  out  NUM_DIGITS  one-hot digit enable.
- frame_start  out  1  one-cycle pulse when digit index wraps to 0.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values:
  - Prescaler = 0, digit index = 0, shadow = all zero, pending = 0, frame_start = 0.
  - seg_out, dp_out and digit_sel are at their inactive level (polarity-adjusted).
- Prescaler counts 0..SCAN_DIV-1 and then wraps. At the wrap the digit index increments; at NUM_DIGITS-1 it wraps to 0.
- Frame boundary is the cycle the index goes NUM_DIGITS-1 -> 0:
  - frame_start = 1 for exactly that one registered cycle.
  - If pending, or if update_req is asserted in that same cycle, shadow <= {bcd_in, dp_in} and pending clears.
- update_req outside a boundary sets pending. Repeated requests are idempotent, and the latest bcd_in at the boundary wins.
- Decode: values 0-9 map to the standard glyphs (0=1111110, 1=0110000, ..., 9=1111011). Values 10-15 are blank (0000000).
- Blank window: digit_sel is all inactive while the prescaler < BLANK_CYCLES. Otherwise it is one-hot on the current index, with seg_out/dp_out for the current digit.
- All outputs are registered: one cycle of latency from prescaler/index/shadow state to the pins.
- en=0:
  - Prescaler and index are synchronously held at 0; outputs are inactive; frame_start = 0.
  - Pending is retained.
  - On en rising, scanning restarts at digit 0 with a full blank window. The first boundary occurs after a complete frame.
- Reset mid-frame: all state clears immediately (async); scanning resumes from digit 0 on release.
- Polarity parameters invert only at the output register, never the internal state.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- With the macro defined: digits above the most significant non-zero shadow digit that hold 0 show blank segments. Their dp still follows dp_in. Digit 0 is never blanked.
- Without the macro: all digits show their value, including zeros.

Decomposition:
- Package seg7_pkg holds:
  - Segment bit-index constants (SEG_A=6 .. SEG_G=0).
  - The 7-bit glyph constants for 0-9 and SEG_BLANK.
  - The 4-bit BCD digit typedef.
- Sub-module seg7_scan_timer (prescaler, digit index, blank window, frame_start generation) is natural.
- Decode and shadow logic stay in the top level.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-high):
1. Reset held, then released -> all outputs 0. First digit_sel=0001 appears on the cycle after the prescaler reaches 2. Each digit lasts 6 active cycles per 8-cycle slot.
2. bcd_in=16'h1234 with update_req pulsed mid-frame -> display unchanged until frame_start. Afterwards seg_out=0110011 (4) with digit_sel=0001 and 1111110→0110000 (1) with digit_sel=1000.
3. update_req asserted exactly on the boundary cycle with bcd_in=16'h0007 -> captured in that frame. Digit 0 shows 1110000; with SEG7_LEADING_ZERO_BLANK_EN digits 1-3 show 0000000, without it they show 1111110.
4. Shadow nibble = 4'hC -> seg_out=0000000 in that slot. dp_in[2]=1 -> dp_out=1 only while digit_sel=0100.
5. en deasserted mid-frame for 5 cycles, then reasserted -> outputs inactive within 1 cycle. Restart at digit 0 after a 2-cycle blank; frame_start fires 32 cycles after restart.
6. reset_n pulsed low asynchronously mid-slot with SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 -> seg_out=1111111, dp_out=1 and digit_sel=1111 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, segment bit positions and glyph table for the 7-segment scan driver.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Active-high glyph; non-decimal codes render dark.
    function automatic seg_t seg7_decode(input bcd_t v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit index for the scan driver; flags the blank window
// and the frame boundary (index wrapping NUM_DIGITS-1 -> 0).
module seg7_scan_timer #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int IW           = $clog2(NUM_DIGITS),
    parameter int PW           = $clog2(SCAN_DIV)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic [IW-1:0] idx,
    output logic          blank,
    output logic          boundary,
    output logic          frame_start
);

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          frame_start_q, frame_start_d;
    logic          wrap;

    always_comb begin
        presc_d  = presc_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        wrap     = (presc_q == PRESC_MAX);
        if (!en) begin
            presc_d = '0;
            idx_d   = '0;
        end else begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            if (wrap)
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            boundary = wrap && (idx_q == IDX_MAX);
        end
        frame_start_d = boundary;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign idx         = idx_q;
    assign blank       = (presc_q < BLANK_END);
    assign frame_start = frame_start_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned shadow load.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  bcd_t [NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  update_req,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    localparam seg_t                  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [IW-1:0] idx;
    logic          blank, boundary;

    seg7_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IW          (IW),
        .PW          (PW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .idx        (idx),
        .blank      (blank),
        .boundary   (boundary),
        .frame_start(frame_start)
    );

    bcd_t [NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                  pending_q, pending_d;

    // A request on the boundary cycle itself loads immediately rather than waiting a frame.
    always_comb begin
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        if (boundary) begin
            if (pending_q || update_req) begin
                shadow_bcd_d = bcd_in;
                shadow_dp_d  = dp_in;
            end
            pending_d = 1'b0;
        end else if (update_req) begin
            pending_d = 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] lz_blank;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic hi_zero;
    always_comb begin
        lz_blank = '0;
        hi_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            hi_zero     = hi_zero && (shadow_bcd_q[i] == 4'd0);
            lz_blank[i] = hi_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    bcd_t                  cur_bcd;
    logic                  cur_dp, cur_lz;
    seg_t                  seg_act;
    logic                  dp_act;
    logic [NUM_DIGITS-1:0] dig_act;
    seg_t                  seg_out_q, seg_out_d;
    logic                  dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    always_comb begin
        cur_bcd = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        dig_act = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_bcd    = shadow_bcd_q[i];
                cur_dp     = shadow_dp_q[i];
                cur_lz     = lz_blank[i];
                dig_act[i] = 1'b1;
            end
        end
        seg_act = SEG_BLANK;
        dp_act  = 1'b0;
        if (!en || blank) begin
            dig_act = '0;
        end else begin
            seg_act = cur_lz ? SEG_BLANK : seg7_decode(cur_bcd);
            dp_act  = cur_dp;
        end
        // Polarity applied only here so internal state stays active-high.
        seg_out_d   = seg_act ^ SEG_OFF;
        dp_out_d    = dp_act ^ DP_OFF;
        digit_sel_d = dig_act ^ DIG_OFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_out_q    <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            digit_sel_q  <= DIG_OFF;
        end else begin
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            seg_out_q    <= seg_out_d;
            dp_out_q     <= dp_out_d;
            digit_sel_q  <= digit_sel_d;
        end
    end

    assign seg_out   = seg_out_q;
    assign dp_out    = dp_out_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: 4 digits, 8-cycle slots, 2-cycle blank; active-high and active-low instances.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic        update_req = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l, fs_h, fs_l;
    logic [3:0]  dig_h, dig_l;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZHI = 7'h00;
`else
    localparam logic [6:0] ZHI = 7'h7e;
`endif

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut_h (
        .clk(clk), .reset_n(reset_n), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
        .update_req(update_req), .seg_out(seg_h), .dp_out(dp_h),
        .digit_sel(dig_h), .frame_start(fs_h)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_l (
        .clk(clk), .reset_n(reset_n), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
        .update_req(update_req), .seg_out(seg_l), .dp_out(dp_l),
        .digit_sel(dig_l), .frame_start(fs_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        int n0, n1, n2, n3, nfs;
        n0 = 0; n1 = 0; n2 = 0; n3 = 0; nfs = 0;

        #12;
        chk("rst_seg_h", seg_h, 7'h00);
        chk("rst_dig_h", dig_h, 4'h0);
        chk("rst_dp_h",  dp_h,  1'b0);
        chk("rst_fs_h",  fs_h,  1'b0);
        chk("rst_seg_l", seg_l, 7'h7f);
        chk("rst_dig_l", dig_l, 4'hf);
        chk("rst_dp_l",  dp_l,  1'b1);
        @(posedge clk);
        #4 reset_n = 1'b1;

        // First frame: blank window then one 6-cycle active slot per digit.
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (dig_h == 4'b0001) n0++;
            if (dig_h == 4'b0010) n1++;
            if (dig_h == 4'b0100) n2++;
            if (dig_h == 4'b1000) n3++;
            if (k < 32 && fs_h) nfs++;
            if (k == 2) chk("blank_first", dig_h, 4'h0);
            if (k == 3) begin
                chk("first_dig", dig_h, 4'b0001);
                chk("first_seg", seg_h, 7'h7e);
                chk("first_seg_l", seg_l, 7'h01);
                chk("first_dig_l", dig_l, 4'he);
                chk("first_dp_l", dp_l, 1'b1);
            end
        end
        chk("slot0_cnt", n0, 6);
        chk("slot1_cnt", n1, 6);
        chk("slot2_cnt", n2, 6);
        chk("slot3_cnt", n3, 6);
        chk("fs_early", nfs, 0);
        chk("fs_frame1", fs_h, 1'b1);

        // Mid-frame request; latest bcd_in at the boundary wins.
        wait_to(40);
        bcd_in = 16'h9999;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        wait_to(44);
        bcd_in = 16'h1234;
        wait_to(59);
        chk("hold_dig", dig_h, 4'b1000);
        chk("hold_seg", seg_h, ZHI);
        wait_to(64);
        chk("fs_frame2", fs_h, 1'b1);
        wait_to(65);
        chk("fs_pulse", fs_h, 1'b0);
        wait_to(67);
        chk("d0_dig", dig_h, 4'b0001);
        chk("d0_seg4", seg_h, 7'h33);
        wait_to(91);
        chk("d3_dig", dig_h, 4'b1000);
        chk("d3_seg1", seg_h, 7'h30);

        // Request exactly on the boundary cycle.
        wait_to(95);
        bcd_in = 16'h0007;
        dp_in = 4'b0100;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        chk("fs_frame3", fs_h, 1'b1);
        wait_to(99);
        chk("b_d0_dig", dig_h, 4'b0001);
        chk("b_d0_seg7", seg_h, 7'h70);
        chk("b_d0_dp", dp_h, 1'b0);

        // Queue 3C21 for the next frame.
        wait_to(100);
        bcd_in = 16'h3c21;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        wait_to(107);
        chk("b_d1_dig", dig_h, 4'b0010);
        chk("b_d1_seg", seg_h, ZHI);
        wait_to(115);
        chk("b_d2_dig", dig_h, 4'b0100);
        chk("b_d2_seg", seg_h, ZHI);
        chk("b_d2_dp", dp_h, 1'b1);

        wait_to(139);
        chk("c_d1_dig", dig_h, 4'b0010);
        chk("c_d1_seg2", seg_h, 7'h6d);
        chk("c_d1_dp", dp_h, 1'b0);
        wait_to(145);
        chk("c_blank_dig", dig_h, 4'h0);
        chk("c_blank_dp", dp_h, 1'b0);
        chk("c_blank_seg", seg_h, 7'h00);
        wait_to(147);
        chk("c_d2_dig", dig_h, 4'b0100);
        chk("c_d2_segC", seg_h, 7'h00);
        chk("c_d2_dp", dp_h, 1'b1);

        // Enable dropped mid-slot for 5 cycles, request queued while off.
        wait_to(165);
        chk("pre_en_dig", dig_h, 4'b0001);
        en = 1'b0;
        tick();
        chk("en0_dig", dig_h, 4'h0);
        chk("en0_seg", seg_h, 7'h00);
        chk("en0_fs", fs_h, 1'b0);
        bcd_in = 16'h0005;
        dp_in = 4'b0000;
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        wait_to(170);
        chk("en0_dig_l", dig_l, 4'hf);
        en = 1'b1;
        wait_to(172);
        chk("re_blank", dig_h, 4'h0);
        wait_to(173);
        chk("re_d0_dig", dig_h, 4'b0001);
        chk("re_d0_seg1", seg_h, 7'h30);
        wait_to(201);
        chk("re_fs_early", fs_h, 1'b0);
        wait_to(202);
        chk("re_fs", fs_h, 1'b1);
        wait_to(205);
        chk("pend_d0_dig", dig_h, 4'b0001);
        chk("pend_d0_seg5", seg_h, 7'h5b);
        chk("pend_seg_l", seg_l, 7'h24);
        chk("pend_dig_l", dig_l, 4'he);

        // Asynchronous reset mid-slot.
        #3 reset_n = 1'b0;
        #1;
        chk("arst_seg_l", seg_l, 7'h7f);
        chk("arst_dp_l",  dp_l,  1'b1);
        chk("arst_dig_l", dig_l, 4'hf);
        chk("arst_dig_h", dig_h, 4'h0);
        chk("arst_seg_h", seg_h, 7'h00);
        #2 reset_n = 1'b1;
        cyc = 0;
        wait_to(2);
        chk("post_blank", dig_h, 4'h0);
        wait_to(3);
        chk("post_dig", dig_h, 4'b0001);
        chk("post_seg", seg_h, 7'h7e);
        chk("post_fs", fs_h, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
